// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    // Bits needed to hold values 0..max_val.
    function automatic int ctr_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation counter for the IF port plus the LS-first priority select.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic ls_req,
    input  logic if_ready,
    input  logic idle,
    output logic grant_if,
    output logic grant_ls
);

    localparam int CNT_W = ctr_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             at_limit;

    assign at_limit = (starve_cnt == LIMIT);

    // Waiting cycles include ARB_WAIT, so a long LS read stream still ages IF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_ready) begin
            starve_cnt <= '0;
        end else if (if_req && !at_limit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign grant_ls = idle && ls_req && !(if_req && at_limit);
    assign grant_if = idle && if_req && !grant_ls;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous memory between instruction fetch
// (read-only) and load/store (read/write), sequencing read latency.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ready,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int LAT_W = ctr_width(READ_LATENCY);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);

    arb_state_t            state;
    arb_owner_t            owner;
    logic [LAT_W-1:0]      lat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic idle;
    logic grant_if;
    logic grant_ls;
    logic read_accept;
    logic read_done;

    assign idle        = (state == ARB_IDLE);
    assign read_accept = grant_if || (grant_ls && !ls_we);
    assign read_done   = (state == ARB_WAIT) && (lat_cnt == LAT_LAST);

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .ls_req  (ls_req),
        .if_ready(if_ready),
        .idle    (idle),
        .grant_if(grant_if),
        .grant_ls(grant_ls)
    );

    // lat_cnt runs 1..READ_LATENCY across ARB_WAIT; data returns on the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARB_IDLE;
            owner   <= OWN_IF;
            lat_cnt <= '0;
            addr_q  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (read_accept) begin
                        state   <= ARB_WAIT;
                        owner   <= grant_ls ? OWN_LS : OWN_IF;
                        addr_q  <= grant_ls ? ls_addr : if_addr;
                        lat_cnt <= LAT_W'(1);
                    end
                end
                ARB_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state   <= ARB_IDLE;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        if_ready  = 1'b0;
        ls_ready  = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        mem_addr  = '0;
        mem_data  = '0;
        mem_we    = 1'b0;
        if (!reset) begin
            if_ready = grant_if;
            ls_ready = grant_ls;
            mem_we   = grant_ls && ls_we;
            if (mem_we) begin
                mem_data = ls_wdata;
            end
            if (state == ARB_WAIT) begin
                mem_addr = addr_q;
            end else if (grant_ls) begin
                mem_addr = ls_addr;
            end else if (grant_if) begin
                mem_addr = if_addr;
            end
            if_rvalid = read_done && (owner == OWN_IF);
            ls_rvalid = read_done && (owner == OWN_LS);
            if (if_rvalid) begin
                if_rdata = mem_q;
            end
            if (ls_rvalid) begin
                ls_rdata = mem_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: READ_LATENCY=1 and READ_LATENCY=3 instances.
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];

    // ---- instance with READ_LATENCY = 1 ----
    logic        if_req, if_ready, if_rvalid, ls_req, ls_we, ls_ready, ls_rvalid, mem_we;
    logic [15:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata, mem_addr, mem_data, mem_q;
    logic [15:0] mem1 [0:65535];
    logic [15:0] rd1;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(1), .STARVE_LIMIT(3)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    always @(posedge clk) begin
        if (mem_we) mem1[mem_addr] <= mem_data;
        rd1 <= mem1[mem_addr];
    end
    assign mem_q = rd1;

    // ---- instance with READ_LATENCY = 3 ----
    logic        if_req3, if_ready3, if_rvalid3, ls_req3, ls_we3, ls_ready3, ls_rvalid3, mem_we3;
    logic [15:0] if_addr3, if_rdata3, ls_addr3, ls_wdata3, ls_rdata3, mem_addr3, mem_data3, mem_q3;
    logic [15:0] mem3 [0:65535];
    logic [15:0] p1, p2, p3;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(3), .STARVE_LIMIT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_ready(ls_ready3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
        .mem_addr(mem_addr3), .mem_data(mem_data3), .mem_we(mem_we3), .mem_q(mem_q3)
    );

    always @(posedge clk) begin
        if (mem_we3) mem3[mem_addr3] <= mem_data3;
        p1 <= mem3[mem_addr3];
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_q3 = p3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int port, input logic [15:0] data, input int lat);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic mon_port(input int port, input logic v, input logic [15:0] d);
        exp_t e;
        if (v) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rvalid: port %0d got data 0x%0h expected no response (cycle %0d)",
                         port, d, cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rvalid_port_p%0d", port), port, e.port);
                chk($sformatf("rvalid_cycle_p%0d", port), cyc, e.cyc);
                chk($sformatf("rdata_p%0d", port), {16'h0, d}, {16'h0, e.data});
            end
        end else begin
            chk($sformatf("rdata_idle_p%0d", port), {16'h0, d}, 32'h0);
        end
    endtask

    // Monitor: every returned read word is matched against the scoreboard.
    always @(negedge clk) begin
        mon_port(0, if_rvalid, if_rdata);
        mon_port(1, ls_rvalid, ls_rdata);
        mon_port(2, if_rvalid3, if_rdata3);
        mon_port(3, ls_rvalid3, ls_rdata3);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        if_req = 0; ls_req = 0; ls_we = 0;
        if_req3 = 0; ls_req3 = 0; ls_we3 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_if_tab;
        logic [7:0] exp_ls_tab;
        int wr;
        exp_if_tab = 8'b1000_1000;
        exp_ls_tab = 8'b0110_0111;
        clear_reqs();
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        if_addr3 = '0; ls_addr3 = '0; ls_wdata3 = '0;

        // Outputs held at zero under reset even with requests pending.
        step();
        if_req = 1; ls_req = 1; ls_we = 1; ls_addr = 16'h1234; ls_wdata = 16'h9999; if_addr = 16'h5678;
        @(negedge clk);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_ls_ready", ls_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        step();
        reset = 0;
        clear_reqs();
        @(negedge clk);
        chk("idle_mem_addr", mem_addr, 0);

        // LS write then LS read of 0x0000.
        step();
        ls_req = 1; ls_we = 1; ls_addr = 16'h0000; ls_wdata = 16'h1111;
        @(negedge clk);
        chk("wr_ls_ready", ls_ready, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_data", mem_data, 16'h1111);
        step();
        ls_we = 0;
        @(negedge clk);
        chk("rd_ls_ready", ls_ready, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_data", mem_data, 0);
        push(1, 16'h1111, 1);
        step();
        ls_we = 1; ls_addr = 16'h0055; ls_wdata = 16'h7777;
        @(negedge clk);
        chk("wait_ls_ready", ls_ready, 0);
        chk("wait_mem_we", mem_we, 0);
        chk("wait_mem_addr", mem_addr, 16'h0000);

        // Back-to-back writes, then simultaneous requests: LS first.
        step();
        ls_addr = 16'h0020; ls_wdata = 16'hAAAA;
        @(negedge clk);
        chk("b2b_wr0_ready", ls_ready, 1);
        step();
        ls_addr = 16'h0030; ls_wdata = 16'hBBBB;
        @(negedge clk);
        chk("b2b_wr1_ready", ls_ready, 1);
        chk("b2b_wr1_addr", mem_addr, 16'h0030);
        step();
        ls_we = 0; ls_addr = 16'h0020; if_req = 1; if_addr = 16'h0030;
        @(negedge clk);
        chk("both_ls_ready", ls_ready, 1);
        chk("both_if_ready", if_ready, 0);
        chk("both_mem_addr", mem_addr, 16'h0020);
        push(1, 16'hAAAA, 1);
        step();
        ls_req = 0;
        @(negedge clk);
        chk("both_wait_if_ready", if_ready, 0);
        step();
        @(negedge clk);
        chk("both_if_ready_next", if_ready, 1);
        chk("both_if_mem_addr", mem_addr, 16'h0030);
        push(0, 16'hBBBB, 1);
        step();
        clear_reqs();

        // Continuous LS writes against a waiting IF: IF forced in on its 4th wait.
        wr = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            ls_req = 1; ls_we = 1;
            ls_addr = 16'(16'h0100 + wr); ls_wdata = 16'(16'h5000 + wr);
            if_req = 1; if_addr = 16'h0030;
            @(negedge clk);
            chk($sformatf("starve_if_ready_c%0d", k + 1), if_ready, exp_if_tab[k]);
            chk($sformatf("starve_ls_ready_c%0d", k + 1), ls_ready, exp_ls_tab[k]);
            if (exp_if_tab[k]) push(0, 16'hBBBB, 1);
            if (ls_ready) wr++;
        end
        step();
        clear_reqs();

        // Top-of-range address forwarded unchanged.
        step();
        ls_req = 1; ls_we = 1; ls_addr = 16'hFFFF; ls_wdata = 16'h4444;
        @(negedge clk);
        chk("ffff_mem_addr", mem_addr, 16'hFFFF);
        chk("ffff_mem_data", mem_data, 16'h4444);
        step();
        clear_reqs();
        if_req = 1; if_addr = 16'hFFFF;
        @(negedge clk);
        chk("ffff_if_ready", if_ready, 1);
        chk("ffff_if_mem_addr", mem_addr, 16'hFFFF);
        push(0, 16'h4444, 1);
        step();
        clear_reqs();

        // Reset during an in-flight read: response dropped.
        step();
        ls_req = 1; ls_we = 0; ls_addr = 16'h0020;
        @(negedge clk);
        chk("rstmid_ls_ready", ls_ready, 1);
        step();
        reset = 1;
        if_req = 1; ls_we = 1; if_addr = 16'h0030;
        @(negedge clk);
        chk("rstmid_ls_rvalid", ls_rvalid, 0);
        chk("rstmid_if_ready", if_ready, 0);
        chk("rstmid_ls_ready", ls_ready, 0);
        chk("rstmid_mem_we", mem_we, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        step();
        reset = 0;
        clear_reqs();
        if_req = 1; if_addr = 16'h0030;
        @(negedge clk);
        chk("postrst_if_ready", if_ready, 1);
        push(0, 16'hBBBB, 1);
        step();
        clear_reqs();
        step();

        // READ_LATENCY=3 instance.
        step();
        ls_req3 = 1; ls_we3 = 1; ls_addr3 = 16'h0040; ls_wdata3 = 16'hC3C3;
        @(negedge clk);
        chk("l3_wr_ready", ls_ready3, 1);
        chk("l3_wr_mem_we", mem_we3, 1);
        step();
        clear_reqs();
        if_req3 = 1; if_addr3 = 16'h0040;
        @(negedge clk);
        chk("l3_if_ready_n", if_ready3, 1);
        push(2, 16'hC3C3, 3);
        for (int i = 1; i <= 3; i++) begin
            step();
            ls_req3 = 1; ls_we3 = 0; ls_addr3 = 16'h0041;
            @(negedge clk);
            chk($sformatf("l3_if_ready_n%0d", i), if_ready3, 0);
            chk($sformatf("l3_ls_ready_n%0d", i), ls_ready3, 0);
            chk($sformatf("l3_mem_addr_n%0d", i), mem_addr3, 16'h0040);
        end
        step();
        @(negedge clk);
        chk("l3_if_ready_n4", if_ready3, 1);
        chk("l3_ls_ready_n4", ls_ready3, 0);
        push(2, 16'hC3C3, 3);
        step();
        clear_reqs();
        for (int i = 0; i < 5; i++) step();

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port 16-bit memory (data/addr/we/clk/q interface, synchronous write) between two requesters: the instruction-fetch port (IF, read-only) and the load/store port (LS, read/write). It uses fixed priority to LS, with an anti-starvation counter that eventually forces a grant to IF. It sequences read latency and returns read data with a one-cycle valid pulse. It sits between the core's fetch/LSU stages and the memory instance.

Parameters:
ADDR_WIDTH, 16, width of every address bus.
DATA_WIDTH, 16, width of every data bus.
READ_LATENCY, 1, cycles from address presented (with we=0) to mem_q valid; legal range 1..4.
STARVE_LIMIT, 3, consecutive IF wait cycles after which IF wins the next arbitration; must be >=1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
if_req  in  1  IF read request; held with if_addr until if_ready.
if_addr  in  ADDR_WIDTH  IF read address.
if_ready  out  1  IF request accepted this cycle.
if_rvalid  out  1  one-cycle pulse, if_rdata valid.
if_rdata  out  DATA_WIDTH  IF read data.
ls_req  in  1  LS request; held with ls_we, ls_addr and ls_wdata until ls_ready.
ls_we  in  1  1 = write, 0 = read.
ls_addr  in  ADDR_WIDTH  LS address.
ls_wdata  in  DATA_WIDTH  LS write data.
ls_ready  out  1  LS request accepted this cycle.
ls_rvalid  out  1  one-cycle pulse, ls_rdata valid (reads only).
ls_rdata  out  DATA_WIDTH  LS read data.
mem_addr  out  ADDR_WIDTH  to memory addr.
mem_data  out  DATA_WIDTH  to memory data.
mem_we  out  1  to memory we.
mem_q  in  DATA_WIDTH  from memory q.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port named reset.
- States:
  - ARB_IDLE: may accept a request.
  - ARB_WAIT: a read is in flight; a latency counter counts READ_LATENCY cycles.
  - An owner register (IF/LS) records which port launched the read.
- Arbitration in ARB_IDLE, combinational, same cycle:
  - Winner is LS if ls_req=1 and !(if_req=1 and starve_cnt==STARVE_LIMIT); otherwise IF if if_req=1.
  - The winner's ready is asserted, and mem_addr is driven from the winner's address.
- LS write accepted (cycle N):
  - mem_we=1 and mem_data=ls_wdata in cycle N; memory writes on the rising edge ending cycle N.
  - State stays ARB_IDLE, so back-to-back writes run at one per cycle.
  - No ls_rvalid is generated.
- Read accepted (cycle N):
  - mem_we=0; state becomes ARB_WAIT at N+1; owner is latched.
  - mem_addr is held at the latched address through ARB_WAIT.
  - In cycle N+READ_LATENCY, the owner's rvalid=1 and its rdata=mem_q (pass-through).
  - State returns to ARB_IDLE at N+READ_LATENCY+1. Read throughput is one per READ_LATENCY+1 cycles.
- In ARB_WAIT: both readys are 0 and mem_we=0; requests are ignored (not queued).
- Outputs when not driving:
  - rdata outputs are 0 whenever their rvalid=0.
  - mem_data=0 when mem_we=0.
  - mem_addr=0 in ARB_IDLE with no request.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on every cycle with if_req=1 and if_ready=0 (ARB_WAIT cycles included).
  - Clears to 0 on if_ready.
  - Width is clog2(STARVE_LIMIT+1).
- A request dropped before ready is simply never serviced; there is no error.
- Address is passed through at full ADDR_WIDTH; the arbiter performs no bounds checking or wrap. 0xFFFF is forwarded unchanged.
- Reset (asynchronous, including mid-read):
  - State ARB_IDLE, starve_cnt=0, latency counter=0, owner=IF.
  - The in-flight read is dropped and no rvalid is issued.
  - While reset=1, every output is forced to 0 regardless of requests.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_WAIT}.
  - arb_owner_t {OWN_IF=0, OWN_LS=1}.
  - Function computing the counter width.
- One sub-module, mem_arb_starve_ctr: the saturating starvation counter plus priority select.
  - Inputs: clk, reset, if_req, ls_req, if_ready, idle.
  - Outputs: grant_if, grant_ls.
- The top level holds the FSM, latency counter and datapath muxing.

Test Plan:
- LS write, ls_addr=0x0000, ls_wdata=0x1111 -> ls_ready=1 and mem_we=1 same cycle. Then LS read of 0x0000 -> ls_rvalid pulse READ_LATENCY cycles later with ls_rdata=0x1111; if_rvalid stays 0.
- if_req and ls_req (read) high together in ARB_IDLE, starve_cnt=0 -> LS granted first. IF granted at the next ARB_IDLE opportunity; if_rdata returns the memory word at if_addr.
- ls_req held high with continuous writes and if_req held high -> if_ready asserts exactly on the 4th IF wait cycle (STARVE_LIMIT=3); starve_cnt is 0 afterward.
- LS read accepted, then reset pulsed in the ARB_WAIT cycle -> no rvalid is produced. All outputs are 0 during reset, and the first cycle after reset is ARB_IDLE.
- LS write of data=0x4444 at addr=0xFFFF -> mem_addr=0xFFFF. Readback of 0xFFFF via IF returns if_rdata=0x4444.
- READ_LATENCY=3 build: IF read accepted at cycle N -> if_rvalid only at N+3; if_ready=0 and ls_ready=0 for cycles N+1..N+3; next accept possible at N+4.
